// File: rtl/hps_word16_event_sequencer.sv
// Avalon-MM poller for a 16-bit input PIO: watches edge capture, clears it, reads the
// input word and queues {timestamp, capture, data} events in a show-ahead FIFO.
module hps_word16_event_sequencer #(
    parameter int FIFO_DEPTH = 16,
    parameter int POLL_DIV   = 50,
    parameter int TS_W       = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    output logic [1:0]                    pio_address,
    output logic                          pio_chipselect,
    output logic                          pio_write_n,
    output logic [31:0]                   pio_writedata,
    input  logic [31:0]                   pio_readdata,
    output logic                          evt_valid,
    output logic [TS_W+31:0]              evt_data,
    input  logic                          evt_pop,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   overflow_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(POLL_DIV);
    localparam int EW = TS_W + 32;
    localparam logic [TW-1:0] RELOAD = TW'(POLL_DIV - 1);

    typedef enum logic [2:0] {IDLE, RD_CAP, WT_CAP, CLR, RD_DAT, WT_DAT, PUSH} state_t;

    state_t          state_q, state_d;
    logic [1:0]      addr_q, addr_d;
    logic            cs_q, cs_d;
    logic            wn_q, wn_d;
    logic [15:0]     cap_q, cap_d;
    logic [15:0]     dat_q, dat_d;
    logic [TS_W-1:0] evt_ts_q, evt_ts_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]   count_q, count_d;
    logic [15:0]     ovf_q, ovf_d;
    logic            poll_tick, push_req, do_push, do_pop;
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic            unused_rd_hi;

    assign unused_rd_hi = ^pio_readdata[31:16];

    always_comb begin
        ts_d      = ts_q + 1'b1;
        poll_tick = (timer_q == '0);
        timer_d   = poll_tick ? RELOAD : timer_q - 1'b1;
        state_d   = state_q;
        cap_d     = cap_q;
        dat_d     = dat_q;
        evt_ts_d  = evt_ts_q;
        push_req  = 1'b0;
        case (state_q)
            IDLE:    if (poll_tick && enable) state_d = RD_CAP;
            RD_CAP:  state_d = WT_CAP;
            WT_CAP: begin
                cap_d   = pio_readdata[15:0];
                state_d = (pio_readdata[15:0] == 16'h0) ? IDLE : CLR;
            end
            CLR: begin
                evt_ts_d = ts_q;
                state_d  = RD_DAT;
            end
            RD_DAT:  state_d = WT_DAT;
            WT_DAT: begin
                dat_d   = pio_readdata[15:0];
                state_d = PUSH;
            end
            PUSH: begin
                push_req = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Bus strobes are registered alongside the state they belong to.
        addr_d = 2'd0;
        cs_d   = 1'b0;
        wn_d   = 1'b1;
        case (state_d)
            RD_CAP: begin addr_d = 2'd3; cs_d = 1'b1; end
            WT_CAP: addr_d = 2'd3;
            CLR:    begin addr_d = 2'd3; cs_d = 1'b1; wn_d = 1'b0; end
            RD_DAT: cs_d = 1'b1;
            default: ;
        endcase
    end

    // Pop is applied before the full test, so a full FIFO can accept a push on a pop cycle.
    always_comb begin
        do_pop   = evt_pop && (count_q != '0);
        do_push  = push_req && ((count_q != LW'(FIFO_DEPTH)) || do_pop);
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q + LW'(do_push) - LW'(do_pop);
        ovf_d    = ovf_q;
        if (push_req && !do_push && (ovf_q != 16'hFFFF))
            ovf_d = ovf_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= 2'd0;
            cs_q     <= 1'b0;
            wn_q     <= 1'b1;
            cap_q    <= '0;
            dat_q    <= '0;
            evt_ts_q <= '0;
            ts_q     <= '0;
            timer_q  <= RELOAD;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cs_q     <= cs_d;
            wn_q     <= wn_d;
            cap_q    <= cap_d;
            dat_q    <= dat_d;
            evt_ts_q <= evt_ts_d;
            ts_q     <= ts_d;
            timer_q  <= timer_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_q] <= {evt_ts_q, cap_q, dat_q};
    end

    assign pio_address    = addr_q;
    assign pio_chipselect = cs_q;
    assign pio_write_n    = wn_q;
    assign pio_writedata  = 32'h0;
    assign evt_valid      = (count_q != '0);
    assign evt_data       = evt_valid ? mem[rd_ptr_q] : '0;
    assign fifo_level     = count_q;
    assign overflow_count = ovf_q;
endmodule

// File: tb/tb_hps_word16_event_sequencer.sv
// Bench for hps_word16_event_sequencer: PIO slave model, scoreboard of expected events,
// and a negedge monitor that checks bus strobes and every popped FIFO entry.
module tb_hps_word16_event_sequencer;
    localparam int FD  = 16;
    localparam int PD  = 50;
    localparam int TSW = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        evt_pop = 1'b0;
    logic [1:0]  pio_address;
    logic        pio_chipselect, pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata = 32'h0;
    logic        evt_valid;
    logic [TSW+31:0] evt_data;
    logic [$clog2(FD):0] fifo_level;
    logic [15:0] overflow_count;

    logic [15:0] pio_in = 16'h0, in_prev = 16'h0, cap = 16'h0;
    int          cyc = 0;
    logic        en_prev = 1'b1;
    int          total = 0, bad = 0, n_rdcap = 0, n_wr = 0;
    logic [47:0] exp_q[$];

    hps_word16_event_sequencer #(.FIFO_DEPTH(FD), .POLL_DIV(PD), .TS_W(TSW)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .pio_address(pio_address), .pio_chipselect(pio_chipselect),
        .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
        .pio_readdata(pio_readdata),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_pop(evt_pop),
        .fifo_level(fifo_level), .overflow_count(overflow_count)
    );

    always #5 clk = ~clk;

    // Any-edge capture PIO; a write to address 3 wins over edges in the same cycle.
    always @(posedge clk) begin
        in_prev <= pio_in;
        if (pio_chipselect && !pio_write_n && pio_address == 2'd3)
            cap <= 16'h0;
        else
            cap <= cap | (pio_in ^ in_prev);
        pio_readdata <= (pio_address == 2'd3) ? {16'h0, cap} : {16'h0, pio_in};
    end

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(posedge clk) en_prev <= enable;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic wait_cyc(input int k);
        if (k < cyc) begin
            total++;
            bad++;
            $display("FAIL wait_cyc: at cycle %0d want %0d", cyc, k);
        end
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] mask_of(input int i);
        return {8'(i + 1), 8'(8'hF0 ^ i)};
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (pio_chipselect && pio_write_n && pio_address == 2'd3) begin
                n_rdcap++;
                check("rdcap_phase", 64'(cyc % PD), 64'd0);
                check("rdcap_enabled", {63'd0, en_prev}, 64'd1);
            end
            if (!pio_write_n) begin
                n_wr++;
                check("clr_strobe", {29'd0, pio_chipselect, pio_address, pio_writedata},
                      {29'd0, 1'b1, 2'd3, 32'h0});
            end
            if (evt_valid && evt_pop) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL evt_pop_data: got %h want <no entry expected>", evt_data);
                end else begin
                    check("evt_pop_data", 64'(evt_data), 64'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [15:0] m;
        logic [47:0] exp_ev;
        int p, n0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bus", {29'd0, pio_address, pio_chipselect, pio_write_n, pio_writedata},
              {29'd0, 2'd0, 1'b0, 1'b1, 32'h0});
        check("rst_fifo", {42'd0, evt_valid, fifo_level, overflow_count}, 64'd0);
        check("rst_evt_data", 64'(evt_data), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Empty polls, then an edge landing in a RD_CAP cycle is held for the next poll.
        wait_cyc(51);
        check("first_poll_count", 64'(n_rdcap), 64'd1);
        wait_cyc(100);
        pio_in = 16'h00A5;
        exp_q.push_back({16'd152, 16'h00A5, 16'h00A5});
        wait_cyc(140);
        check("empty_poll_no_write", 64'(n_wr), 64'd0);
        wait_cyc(160);
        check("level_after_a5", 64'(fifo_level), 64'd1);
        check("writes_after_a5", 64'(n_wr), 64'd1);
        evt_pop = 1'b1;
        wait_cyc(161);
        evt_pop = 1'b0;
        wait_cyc(165);
        check("level_drained", 64'(fifo_level), 64'd0);

        // Seventeen events with no pops: the last one overflows.
        for (int i = 0; i < 17; i++) begin
            p = 200 + 50 * i;
            wait_cyc(p - 20);
            m = mask_of(i);
            pio_in = pio_in ^ m;
            if (i < 16) exp_q.push_back({16'(p + 2), m, pio_in});
        end
        wait_cyc(1010);
        check("level_full", 64'(fifo_level), 64'd16);
        check("overflow_one", 64'(overflow_count), 64'd1);
        check("head_is_first", 64'(evt_data), 64'(exp_q[0]));

        // Pop in the PUSH cycle while full: push accepted, level unchanged.
        wait_cyc(1030);
        m = mask_of(17);
        pio_in = pio_in ^ m;
        exp_q.push_back({16'd1052, m, pio_in});
        wait_cyc(1055);
        evt_pop = 1'b1;
        wait_cyc(1056);
        evt_pop = 1'b0;
        wait_cyc(1060);
        check("level_full_after_pop_push", 64'(fifo_level), 64'd16);
        check("overflow_unchanged", 64'(overflow_count), 64'd1);
        wait_cyc(1070);
        evt_pop = 1'b1;
        wait_cyc(1086);
        evt_pop = 1'b0;
        wait_cyc(1090);
        check("level_after_drain", 64'(fifo_level), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        // Drop enable in CLR: sequence still finishes, next poll is suppressed.
        wait_cyc(1130);
        pio_in = pio_in ^ 16'h3C00;
        exp_ev = {16'd1152, 16'h3C00, pio_in};
        wait_cyc(1152);
        check("in_clr_cycle", {63'd0, pio_write_n}, 64'd0);
        enable = 1'b0;
        wait_cyc(1160);
        check("level_en_off", 64'(fifo_level), 64'd1);
        check("event_en_off", 64'(evt_data), 64'(exp_ev));
        wait_cyc(1230);
        check("no_poll_disabled", 64'(n_rdcap), 64'd23);
        enable = 1'b1;

        // Reset during RD_DAT.
        wait_cyc(1280);
        pio_in = pio_in ^ 16'h0001;
        wait_cyc(1303);
        check("in_rd_dat", {61'd0, pio_chipselect, pio_address, pio_write_n},
              {61'd0, 1'b1, 2'd0, 1'b1});
        reset = 1'b1;
        #1;
        check("async_rst_bus", {62'd0, pio_chipselect, pio_write_n}, 64'd1);
        check("async_rst_fifo", {42'd0, evt_valid, fifo_level, overflow_count}, 64'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_cyc(49);
        n0 = n_rdcap;
        wait_cyc(51);
        check("poll_after_reset", 64'(n_rdcap - n0), 64'd1);
        check("total_polls", 64'(n_rdcap), 64'd26);
        check("total_writes", 64'(n_wr), 64'd21);
        wait_cyc(60);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hps_word16_event_sequencer.md
Name: hps_word16_event_sequencer

Overview:
- Avalon-MM master that drives the 16-bit input PIO slave (data register at address 0, edge-capture register at address 3; any write to address 3 clears all capture bits).
- Periodically polls edge capture. On a non-zero capture it clears the register, reads the input word, and pushes a timestamped event into an internal show-ahead FIFO.
- The HPS-side logic drains the FIFO. The HPS no longer has to poll the PIO itself.

Parameters:
- FIFO_DEPTH, 16, number of event entries; power of 2, minimum 4.
- POLL_DIV, 50, clock cycles between poll starts; minimum 8.
- TS_W, 16, timestamp width in bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; asynchronous, active-high.
- enable  in  1  1 = polling allowed.
- pio_address  out  2  PIO register address.
- pio_chipselect  out  1  PIO chipselect, active-high.
- pio_write_n  out  1  PIO write strobe, active-low.
- pio_writedata  out  32  PIO write data; always 0.
- pio_readdata  in  32  PIO read data; registered in the slave, so valid the cycle after the address is presented.
- evt_valid  out  1  FIFO not empty.
- evt_data  out  TS_W+32  head entry {timestamp, capture[15:0], data[15:0]}.
- evt_pop  in  1  consume the head entry when evt_valid=1.
- fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy.
- overflow_count  out  16  events dropped because the FIFO was full; saturating.

Behaviour:
- Reset: one clock, asynchronous, active-high. While reset=1 and on its release, all outputs are 0 except pio_write_n=1; FSM in IDLE; poll timer=POLL_DIV-1; timestamp=0; FIFO empty.
- Timestamp: free-running TS_W-bit counter, +1 every cycle, wraps to 0.
- Poll timer: counts down every cycle. On reaching 0 it reloads POLL_DIV-1 and raises the poll tick.
- FSM:
  - IDLE: address=0, chipselect=0, write_n=1. On (poll tick && enable) -> RD_CAP. A tick with enable=0 is discarded.
  - RD_CAP: address=3, chipselect=1, write_n=1. -> WT_CAP.
  - WT_CAP: address=3. Latch pio_readdata[15:0] into cap_reg. If cap_reg would be 0 -> IDLE, else -> CLR.
  - CLR: address=3, chipselect=1, write_n=0, writedata=0, for exactly one cycle. Latch the timestamp into ts_reg. -> RD_DAT.
  - RD_DAT: address=0, chipselect=1. -> WT_DAT.
  - WT_DAT: latch pio_readdata[15:0] into dat_reg. -> PUSH.
  - PUSH: write {ts_reg, cap_reg, dat_reg} into the FIFO. -> IDLE.
- Latency: a full event sequence is 6 cycles from leaving IDLE; an empty poll is 2 cycles.
- enable deasserted mid-sequence: the current sequence completes; no new poll starts.
- A poll tick arriving while the FSM is not in IDLE is dropped; the timer keeps running.
- Known limitation: an edge the PIO detects in the CLR cycle is lost, because the slave's clear has priority. The bench verifies that edges in any other cycle are retained for the next poll.
- FIFO:
  - Show-ahead: evt_data is the head entry, valid whenever evt_valid=1.
  - Pop and push are evaluated in the same cycle. The pop takes effect first, so a push into a full FIFO with a simultaneous pop succeeds and the level is unchanged.
  - Push while full without pop: entry dropped, overflow_count+1, saturating at 16'hFFFF. The PIO capture has already been cleared in that case.
  - evt_pop while empty: ignored.
  - fifo_level ranges 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- Reset mid-sequence: FSM returns to IDLE and all PIO strobes deassert immediately. FIFO contents and overflow_count are discarded.

Test Plan:
- No edges, enable=1, POLL_DIV=50 -> a RD_CAP read every 50 cycles; never a write strobe; evt_valid stays 0.
- Input changes 0x0000 -> 0x00A5 before a poll -> exactly one write to address 3; evt_data = {ts, 0x00A5, 0x00A5}; ts = timestamp at CLR; fifo_level=1.
- 17 events with FIFO_DEPTH=16 and no pops -> fifo_level=16; overflow_count=1; head entry is the first event.
- FIFO full, then evt_pop asserted in the PUSH cycle -> fifo_level stays 16; overflow_count unchanged; new entry at the tail.
- enable dropped during CLR -> sequence completes to PUSH; no further RD_CAP while enable=0.
- Reset asserted during RD_DAT -> chipselect=0 and write_n=1 asynchronously; fifo_level=0; after release the first RD_CAP occurs POLL_DIV cycles later.
